// File: rtl/cpu_pkg.sv
// Shared pipeline constants: field widths, ALU/MEM/CTRL op codes, exception codes
// and the multiplier FSM state type.
package cpu_pkg;

   localparam int WORD_DATA = 32;
   localparam int WORD_ADDR = 30;
   localparam int REG_ADDR  = 5;
   localparam int ALU_OP    = 4;
   localparam int MEM_OP    = 2;
   localparam int CTRL_OP   = 2;
   localparam int ISA_EXP   = 3;

   localparam logic [ALU_OP-1:0] ALU_OP_NOP  = 4'd0;
   localparam logic [ALU_OP-1:0] ALU_OP_AND  = 4'd1;
   localparam logic [ALU_OP-1:0] ALU_OP_OR   = 4'd2;
   localparam logic [ALU_OP-1:0] ALU_OP_XOR  = 4'd3;
   localparam logic [ALU_OP-1:0] ALU_OP_ADDS = 4'd4;
   localparam logic [ALU_OP-1:0] ALU_OP_ADDU = 4'd5;
   localparam logic [ALU_OP-1:0] ALU_OP_SUBS = 4'd6;
   localparam logic [ALU_OP-1:0] ALU_OP_SUBU = 4'd7;
   localparam logic [ALU_OP-1:0] ALU_OP_SHRL = 4'd8;
   localparam logic [ALU_OP-1:0] ALU_OP_SHLL = 4'd9;
   localparam logic [ALU_OP-1:0] ALU_OP_MUL  = 4'd10;

   localparam logic [MEM_OP-1:0]  MEM_OP_NOP  = 2'd0;
   localparam logic [CTRL_OP-1:0] CTRL_OP_NOP = 2'd0;

   localparam logic [ISA_EXP-1:0] ISA_EXC_NO_EXP     = 3'd0;
   localparam logic [ISA_EXP-1:0] ISA_EXC_EXT_INT    = 3'd1;
   localparam logic [ISA_EXP-1:0] ISA_EXC_UNDEF_INSN = 3'd2;
   localparam logic [ISA_EXP-1:0] ISA_EXC_OVERFLOW   = 3'd3;
   localparam logic [ISA_EXP-1:0] ISA_EXC_MISALIGN   = 3'd4;
   localparam logic [ISA_EXP-1:0] ISA_EXC_TRAP       = 3'd5;
   localparam logic [ISA_EXP-1:0] ISA_EXC_PRV_VIO    = 3'd6;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage; slave is the EX side,
// master is the decode/pipeline side.
interface ex_stage_if;
   import cpu_pkg::*;

   logic                 id_en_;
   logic [WORD_ADDR-1:0] id_pc;
   logic [ALU_OP-1:0]    id_alu_op;
   logic [WORD_DATA-1:0] id_alu_in_0;
   logic [WORD_DATA-1:0] id_alu_in_1;
   logic                 id_br_flag;
   logic [MEM_OP-1:0]    id_mem_op;
   logic [WORD_DATA-1:0] id_mem_wr_data;
   logic [CTRL_OP-1:0]   id_ctrl_op;
   logic [REG_ADDR-1:0]  id_dst_addr;
   logic                 id_gpr_we_;
   logic [ISA_EXP-1:0]   id_exp_code;

   logic [WORD_DATA-1:0] fwd_data;
   logic                 ex_en_;
   logic [WORD_ADDR-1:0] ex_pc;
   logic                 ex_br_flag;
   logic [MEM_OP-1:0]    ex_mem_op;
   logic [WORD_DATA-1:0] ex_mem_wr_data;
   logic [CTRL_OP-1:0]   ex_ctrl_op;
   logic [REG_ADDR-1:0]  ex_dst_addr;
   logic                 ex_gpr_we_;
   logic [ISA_EXP-1:0]   ex_exp_code;
   logic [WORD_DATA-1:0] ex_out;

   modport master (
      output id_en_, id_pc, id_alu_op, id_alu_in_0, id_alu_in_1, id_br_flag,
             id_mem_op, id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_, id_exp_code,
      input  fwd_data, ex_en_, ex_pc, ex_br_flag, ex_mem_op, ex_mem_wr_data,
             ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out
   );

   modport slave (
      input  id_en_, id_pc, id_alu_op, id_alu_in_0, id_alu_in_1, id_br_flag,
             id_mem_op, id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_, id_exp_code,
      output fwd_data, ex_en_, ex_pc, ex_br_flag, ex_mem_op, ex_mem_wr_data,
             ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out
   );

endinterface

// File: rtl/ex_mul.sv
// Iterative 32-step shift-add multiplier (low 32 bits of the unsigned product)
// with IDLE/BUSY/DONE control and a 6-bit step counter.
module ex_mul
   import cpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_start,
   input  logic                 i_flush,
   input  logic                 i_stall,
   input  logic [WORD_DATA-1:0] i_in_0,
   input  logic [WORD_DATA-1:0] i_in_1,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [WORD_DATA-1:0] o_product
);

   mul_state_t           r_state;
   mul_state_t           w_next;
   logic [5:0]           r_cnt;
   logic [WORD_DATA-1:0] r_mcand;
   logic [WORD_DATA-1:0] r_mplier;
   logic [WORD_DATA-1:0] r_prod;
   logic                 w_abort;

   // stall outranks flush, so a stalled flush must not abort the multiply
   assign w_abort   = i_flush & ~i_stall;
   assign o_product = r_prod;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= MUL_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      o_busy = 1'b0;
      o_done = 1'b0;
      case (r_state)
         MUL_IDLE: begin
            if (i_start) begin
               w_next = MUL_BUSY;
               o_busy = 1'b1;
            end
         end
         MUL_BUSY: begin
            if (w_abort) begin
               w_next = MUL_IDLE;
            end else begin
               o_busy = 1'b1;
               if (r_cnt == 6'd31) w_next = MUL_DONE;
            end
         end
         MUL_DONE: begin
            o_done = 1'b1;
            if (!i_stall) w_next = MUL_IDLE;
         end
         default: w_next = MUL_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
      end else if (r_state == MUL_IDLE && i_start) begin
         r_cnt    <= '0;
         r_mcand  <= i_in_0;
         r_mplier <= i_in_1;
         r_prod   <= '0;
      end else if (r_state == MUL_BUSY) begin
         if (r_mplier[0]) r_prod <= r_prod + r_mcand;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 6'd1;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, signed-overflow detection, forwarding result and EX/MEM registers.
// Define ALU_MUL_EN to include the iterative multiplier (ex_mul); otherwise MUL is undefined.
module ex_stage
   import cpu_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     stall,
   input  logic     flush,
   output logic     mul_busy,
   ex_stage_if.slave bus
);

   logic [WORD_DATA-1:0] w_a;
   logic [WORD_DATA-1:0] w_b;
   logic [WORD_DATA-1:0] w_result;
   logic [WORD_DATA-1:0] w_mul_result;
   logic                 w_ovf;
   logic                 w_undef;

   logic                 r_en_;
   logic [WORD_ADDR-1:0] r_pc;
   logic                 r_br_flag;
   logic [MEM_OP-1:0]    r_mem_op;
   logic [WORD_DATA-1:0] r_mem_wr_data;
   logic [CTRL_OP-1:0]   r_ctrl_op;
   logic [REG_ADDR-1:0]  r_dst_addr;
   logic                 r_gpr_we_;
   logic [ISA_EXP-1:0]   r_exp_code;
   logic [WORD_DATA-1:0] r_out;

   assign w_a = bus.id_alu_in_0;
   assign w_b = bus.id_alu_in_1;

`ifdef ALU_MUL_EN
   logic                 w_mul_start;
   logic                 w_mul_done;
   logic [WORD_DATA-1:0] w_mul_prod;

   assign w_mul_start = ~bus.id_en_ & (bus.id_alu_op == ALU_OP_MUL) & ~flush;

   ex_mul u_mul (
      .clk      (clk),
      .reset    (reset),
      .i_start  (w_mul_start),
      .i_flush  (flush),
      .i_stall  (stall),
      .i_in_0   (w_a),
      .i_in_1   (w_b),
      .o_busy   (mul_busy),
      .o_done   (w_mul_done),
      .o_product(w_mul_prod)
   );

   assign w_mul_result = w_mul_done ? w_mul_prod : '0;
   assign w_undef      = 1'b0;
`else
   assign mul_busy     = 1'b0;
   assign w_mul_result = '0;
   assign w_undef      = (bus.id_alu_op == ALU_OP_MUL);
`endif

   always_comb begin
      w_result = '0;
      case (bus.id_alu_op)
         ALU_OP_NOP:  w_result = w_a;
         ALU_OP_AND:  w_result = w_a & w_b;
         ALU_OP_OR:   w_result = w_a | w_b;
         ALU_OP_XOR:  w_result = w_a ^ w_b;
         ALU_OP_ADDS,
         ALU_OP_ADDU: w_result = w_a + w_b;
         ALU_OP_SUBS,
         ALU_OP_SUBU: w_result = w_a - w_b;
         ALU_OP_SHRL: w_result = w_a >> w_b[4:0];
         ALU_OP_SHLL: w_result = w_a << w_b[4:0];
         ALU_OP_MUL:  w_result = w_mul_result;
         default:     w_result = '0;
      endcase
   end

   always_comb begin
      w_ovf = 1'b0;
      case (bus.id_alu_op)
         ALU_OP_ADDS: w_ovf = (w_a[31] == w_b[31]) && (w_result[31] != w_a[31]);
         ALU_OP_SUBS: w_ovf = (w_a[31] != w_b[31]) && (w_result[31] != w_a[31]);
         default:     w_ovf = 1'b0;
      endcase
   end

   assign bus.fwd_data = w_result;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_en_         <= 1'b1;
         r_pc          <= '0;
         r_br_flag     <= 1'b0;
         r_mem_op      <= MEM_OP_NOP;
         r_mem_wr_data <= '0;
         r_ctrl_op     <= CTRL_OP_NOP;
         r_dst_addr    <= '0;
         r_gpr_we_     <= 1'b1;
         r_exp_code    <= ISA_EXC_NO_EXP;
         r_out         <= '0;
      end else if (!(stall || mul_busy)) begin
         if (flush) begin
            r_en_         <= 1'b1;
            r_pc          <= '0;
            r_br_flag     <= 1'b0;
            r_mem_op      <= MEM_OP_NOP;
            r_mem_wr_data <= '0;
            r_ctrl_op     <= CTRL_OP_NOP;
            r_dst_addr    <= '0;
            r_gpr_we_     <= 1'b1;
            r_exp_code    <= ISA_EXC_NO_EXP;
            r_out         <= '0;
         end else begin
            r_en_         <= bus.id_en_;
            r_pc          <= bus.id_pc;
            r_br_flag     <= bus.id_br_flag;
            r_mem_op      <= bus.id_mem_op;
            r_mem_wr_data <= bus.id_mem_wr_data;
            r_ctrl_op     <= bus.id_ctrl_op;
            r_dst_addr    <= bus.id_dst_addr;
            r_gpr_we_     <= bus.id_gpr_we_;
            r_exp_code    <= bus.id_exp_code;
            r_out         <= w_result;
            // a faulting instruction keeps its fields but must not write back or access memory
            if (!bus.id_en_ && (w_ovf || w_undef)) begin
               r_gpr_we_  <= 1'b1;
               r_mem_op   <= MEM_OP_NOP;
               r_exp_code <= w_ovf ? ISA_EXC_OVERFLOW : ISA_EXC_UNDEF_INSN;
            end
         end
      end
   end

   assign bus.ex_en_         = r_en_;
   assign bus.ex_pc          = r_pc;
   assign bus.ex_br_flag     = r_br_flag;
   assign bus.ex_mem_op      = r_mem_op;
   assign bus.ex_mem_wr_data = r_mem_wr_data;
   assign bus.ex_ctrl_op     = r_ctrl_op;
   assign bus.ex_dst_addr    = r_dst_addr;
   assign bus.ex_gpr_we_     = r_gpr_we_;
   assign bus.ex_exp_code    = r_exp_code;
   assign bus.ex_out         = r_out;

endmodule
